// File: rtl/plot_decoder_pkg.sv
// plot_pkg: definitions shared by the XBee serial receive path (plot_decoder)
// and the matching transmit encoder.
//   stateT       receiver FSM states
//   START_BIT    line level of a start bit
//   STOP_BIT     line level of a valid stop bit
//   IDLE_LVL     line level between frames
//   evenParity   even parity (XOR reduce) of a zero-extended data word
package plot_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } stateT;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  // Callers cast their word up to this width; zero padding leaves the XOR unchanged.
  localparam int PAR_MAX_W = 32;

  function automatic logic evenParity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/plot_decoder_if.sv
// plot_decoder_if: serial line input plus received-byte output bundle.
//   Tick       in   oversampling enable (one Clk wide)
//   RxIn       in   asynchronous serial line, idle high
//   Dout       out  last received byte
//   DataValid  out  one-Clk strobe per completed frame
//   ParityErr  out  parity mismatch on last frame
//   FrameErr   out  stop bit was 0 on last frame
//   Busy       out  receiver not idle
// master = line/tick source and byte consumer, slave = the decoder.
interface plot_decoder_if #(
  parameter int DATA_W = 8
);
  logic              Tick;
  logic              RxIn;
  logic [DATA_W-1:0] Dout;
  logic              DataValid;
  logic              ParityErr;
  logic              FrameErr;
  logic              Busy;

  modport master (
    output Tick, RxIn,
    input  Dout, DataValid, ParityErr, FrameErr, Busy
  );

  modport slave (
    input  Tick, RxIn,
    output Dout, DataValid, ParityErr, FrameErr, Busy
  );
endinterface

// File: rtl/plot_decoder_rx_sync.sv
// rx_sync: two-flop synchronizer for the asynchronous serial line.
// Resets to the idle line level so a reset never looks like a start bit.
//   Clk    in   system clock
//   Reset  in   synchronous, active-high reset
//   D      in   asynchronous input
//   Q      out  synchronized output (2 Clk latency)
module rx_sync
  import plot_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic D,
  output logic Q
);
  logic meta;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      meta <= IDLE_LVL;
      Q    <= IDLE_LVL;
    end else begin
      meta <= D;
      Q    <= meta;
    end
  end
endmodule

// File: rtl/plot_decoder.sv
// plot_decoder: receiver for the 11-bit XBee frame
//   start(0), DATA_W data bits MSB first, even parity, stop(1).
// The line is sampled mid-bit on the oversampling tick; each completed frame
// (good or bad) produces a one-Clk DataValid with Dout/ParityErr/FrameErr
// updated on that same cycle and held until the next frame.
//   Clk    in   system clock
//   Reset  in   synchronous, active-high reset
//   bus    slave side of plot_decoder_if (Tick, RxIn in; results out)
// OVERSAMPLE must be even and >= 4.
//
// state  | meaning
// IDLE   | waiting; arms once the line is seen high, then waits for a low
// START  | half a bit period into the start bit to reject glitches
// DATA   | sampling DATA_W data bits at their centres
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit, then publishing the frame
module plot_decoder
  import plot_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_W     = 8
) (
  input logic           Clk,
  input logic           Reset,
  plot_decoder_if.slave bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);

  logic              rxS;
  stateT             state, stateNxt;
  logic              armed, armedNxt;
  logic [TW-1:0]     tCnt, tCntNxt;
  logic [BW-1:0]     bCnt, bCntNxt;
  logic [DATA_W-1:0] shReg, shRegNxt;
  logic              pBit, pBitNxt;
  logic              frameDone;
  logic              tickEn;
  logic [DATA_W-1:0] dout;
  logic              dataValid;
  logic              parityErr;
  logic              frameErr;

  rx_sync uSync (
    .Clk   (Clk),
    .Reset (Reset),
    .D     (bus.RxIn),
    .Q     (rxS)
  );

  // The publish cycle always lands in IDLE; a tick there is dropped so the
  // line level is not re-evaluated while results are being presented.
  assign tickEn = bus.Tick && !(dataValid && (state == IDLE));

  always_comb begin
    stateNxt  = state;
    armedNxt  = armed;
    tCntNxt   = tCnt;
    bCntNxt   = bCnt;
    shRegNxt  = shReg;
    pBitNxt   = pBit;
    frameDone = 1'b0;
    if (tickEn) begin
      case (state)
        IDLE: begin
          if (rxS == IDLE_LVL) begin
            armedNxt = 1'b1;
          end else if (armed) begin
            stateNxt = START;
            tCntNxt  = '0;
          end
        end
        START: begin
          if (tCnt == T_HALF) begin
            tCntNxt = '0;
            if (rxS != START_BIT) begin
              stateNxt = IDLE;        // glitch; armed stays set
            end else begin
              bCntNxt  = '0;
              stateNxt = DATA;
            end
          end else begin
            tCntNxt = tCnt + 1'b1;
          end
        end
        DATA: begin
          if (tCnt == T_FULL) begin
            shRegNxt = {shReg[DATA_W-2:0], rxS};
            tCntNxt  = '0;
            bCntNxt  = bCnt + 1'b1;
            if (bCnt == B_LAST) stateNxt = PARITY;
          end else begin
            tCntNxt = tCnt + 1'b1;
          end
        end
        PARITY: begin
          if (tCnt == T_FULL) begin
            pBitNxt  = rxS;
            tCntNxt  = '0;
            stateNxt = STOP;
          end else begin
            tCntNxt = tCnt + 1'b1;
          end
        end
        STOP: begin
          if (tCnt == T_FULL) begin
            frameDone = 1'b1;
            tCntNxt   = '0;
            armedNxt  = 1'b0;         // a held-low break must go high before re-arming
            stateNxt  = IDLE;
          end else begin
            tCntNxt = tCnt + 1'b1;
          end
        end
        default: stateNxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      armed     <= 1'b0;
      tCnt      <= '0;
      bCnt      <= '0;
      shReg     <= '0;
      pBit      <= 1'b0;
      dout      <= '0;
      dataValid <= 1'b0;
      parityErr <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      state     <= stateNxt;
      armed     <= armedNxt;
      tCnt      <= tCntNxt;
      bCnt      <= bCntNxt;
      shReg     <= shRegNxt;
      pBit      <= pBitNxt;
      dataValid <= frameDone;
      if (frameDone) begin
        dout      <= shReg;
        parityErr <= (pBit != evenParity(PAR_MAX_W'(shReg)));
        frameErr  <= (rxS != STOP_BIT);
      end
    end
  end

  assign bus.Dout      = dout;
  assign bus.DataValid = dataValid;
  assign bus.ParityErr = parityErr;
  assign bus.FrameErr  = frameErr;
  assign bus.Busy      = (state != IDLE);
endmodule

// File: tb/tb_plot_decoder.sv
module tb_plot_decoder;
  localparam int OS = 16;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  logic [7:0] capDout[$];
  logic       capPerr[$];
  logic       capFerr[$];

  plot_decoder_if #(.DATA_W(8)) bus ();

  plot_decoder #(.OVERSAMPLE(OS), .DATA_W(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Tick: one Clk wide, every 4 Clk
  initial begin
    bus.Tick = 1'b0;
    forever begin
      repeat (3) @(negedge Clk);
      bus.Tick = 1'b1;
      @(negedge Clk);
      bus.Tick = 1'b0;
    end
  end

  always @(negedge Clk) begin
    if (bus.DataValid === 1'b1) begin
      capDout.push_back(bus.Dout);
      capPerr.push_back(bus.ParityErr);
      capFerr.push_back(bus.FrameErr);
    end
  end

  task automatic waitTicks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      while (bus.Tick !== 1'b1) @(posedge Clk);
    end
    #1;
  endtask

  task automatic sendBit(input logic b);
    bus.RxIn = b;
    waitTicks(OS);
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic par, input logic stp);
    sendBit(1'b0);
    for (int i = 7; i >= 0; i--) sendBit(d[i]);
    sendBit(par);
    sendBit(stp);
  endtask

  task automatic test_reset;
    bus.RxIn = 1'b1;
    Reset = 1'b1;
    repeat (5) @(posedge Clk);
    #1;
    checks++; if (bus.Dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", bus.Dout); end
    checks++; if (bus.DataValid !== 1'b0) begin errors++; $display("FAIL reset_dv got %b exp 0", bus.DataValid); end
    checks++; if (bus.ParityErr !== 1'b0) begin errors++; $display("FAIL reset_perr got %b exp 0", bus.ParityErr); end
    checks++; if (bus.FrameErr !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", bus.FrameErr); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.Busy); end
    Reset = 1'b0;
    sendBit(1'b1);
  endtask

  task automatic test_nominal;
    int base;
    base = capDout.size();
    sendFrame(8'h26, 1'b1, 1'b1);
    sendBit(1'b1);
    checks++; if (capDout.size() - base != 1) begin errors++; $display("FAIL nom_count got %0d exp 1", capDout.size() - base); end
    if (capDout.size() - base >= 1) begin
      checks++; if (capDout[base] !== 8'h26) begin errors++; $display("FAIL nom_dout got %h exp 26", capDout[base]); end
      checks++; if (capPerr[base] !== 1'b0) begin errors++; $display("FAIL nom_perr got %b exp 0", capPerr[base]); end
      checks++; if (capFerr[base] !== 1'b0) begin errors++; $display("FAIL nom_ferr got %b exp 0", capFerr[base]); end
    end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL nom_busy got %b exp 0", bus.Busy); end
    checks++; if (bus.Dout !== 8'h26) begin errors++; $display("FAIL nom_dout_held got %h exp 26", bus.Dout); end
  endtask

  task automatic test_parity;
    int base;
    base = capDout.size();
    sendFrame(8'hA5, 1'b1, 1'b1);
    sendBit(1'b1);
    checks++; if (capDout.size() - base != 1) begin errors++; $display("FAIL par_count got %0d exp 1", capDout.size() - base); end
    if (capDout.size() - base >= 1) begin
      checks++; if (capDout[base] !== 8'hA5) begin errors++; $display("FAIL par_dout got %h exp a5", capDout[base]); end
      checks++; if (capPerr[base] !== 1'b1) begin errors++; $display("FAIL par_perr got %b exp 1", capPerr[base]); end
      checks++; if (capFerr[base] !== 1'b0) begin errors++; $display("FAIL par_ferr got %b exp 0", capFerr[base]); end
    end
    checks++; if (bus.ParityErr !== 1'b1) begin errors++; $display("FAIL par_perr_held got %b exp 1", bus.ParityErr); end
    base = capDout.size();
    sendFrame(8'h01, 1'b1, 1'b1);
    sendBit(1'b1);
    checks++; if (capDout.size() - base != 1) begin errors++; $display("FAIL par2_count got %0d exp 1", capDout.size() - base); end
    if (capDout.size() - base >= 1) begin
      checks++; if (capDout[base] !== 8'h01) begin errors++; $display("FAIL par2_dout got %h exp 01", capDout[base]); end
      checks++; if (capPerr[base] !== 1'b0) begin errors++; $display("FAIL par2_perr got %b exp 0", capPerr[base]); end
    end
  endtask

  task automatic test_break;
    int base;
    base = capDout.size();
    sendFrame(8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) sendBit(1'b0);
    checks++; if (capDout.size() - base != 1) begin errors++; $display("FAIL brk_count got %0d exp 1", capDout.size() - base); end
    if (capDout.size() - base >= 1) begin
      checks++; if (capDout[base] !== 8'h3C) begin errors++; $display("FAIL brk_dout got %h exp 3c", capDout[base]); end
      checks++; if (capFerr[base] !== 1'b1) begin errors++; $display("FAIL brk_ferr got %b exp 1", capFerr[base]); end
      checks++; if (capPerr[base] !== 1'b0) begin errors++; $display("FAIL brk_perr got %b exp 0", capPerr[base]); end
    end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL brk_busy got %b exp 0", bus.Busy); end
    checks++; if (bus.FrameErr !== 1'b1) begin errors++; $display("FAIL brk_ferr_held got %b exp 1", bus.FrameErr); end
    sendBit(1'b1);
    sendBit(1'b1);
    base = capDout.size();
    sendFrame(8'h3C, 1'b0, 1'b1);
    sendBit(1'b1);
    checks++; if (capDout.size() - base != 1) begin errors++; $display("FAIL brk2_count got %0d exp 1", capDout.size() - base); end
    if (capDout.size() - base >= 1) begin
      checks++; if (capDout[base] !== 8'h3C) begin errors++; $display("FAIL brk2_dout got %h exp 3c", capDout[base]); end
      checks++; if (capFerr[base] !== 1'b0) begin errors++; $display("FAIL brk2_ferr got %b exp 0", capFerr[base]); end
    end
  endtask

  task automatic test_glitch;
    int base;
    base = capDout.size();
    bus.RxIn = 1'b0;
    waitTicks(3);
    checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL glt_busy_hi got %b exp 1", bus.Busy); end
    waitTicks(2);
    bus.RxIn = 1'b1;
    waitTicks(8);
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL glt_busy_lo got %b exp 0", bus.Busy); end
    sendBit(1'b1);
    checks++; if (capDout.size() - base != 0) begin errors++; $display("FAIL glt_count got %0d exp 0", capDout.size() - base); end
    checks++; if (bus.Dout !== 8'h3C) begin errors++; $display("FAIL glt_dout got %h exp 3c", bus.Dout); end
  endtask

  task automatic test_back_to_back;
    int base;
    logic [7:0] expD[3];
    expD[0] = 8'h00; expD[1] = 8'hFF; expD[2] = 8'h80;
    base = capDout.size();
    sendFrame(8'h00, 1'b0, 1'b1);
    sendBit(1'b1);
    sendFrame(8'hFF, 1'b0, 1'b1);
    sendBit(1'b1);
    sendFrame(8'h80, 1'b1, 1'b1);
    sendBit(1'b1);
    checks++; if (capDout.size() - base != 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", capDout.size() - base); end
    if (capDout.size() - base >= 3) begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (capDout[base+i] !== expD[i]) begin errors++; $display("FAIL b2b_dout%0d got %h exp %h", i, capDout[base+i], expD[i]); end
        checks++; if ({capPerr[base+i], capFerr[base+i]} !== 2'b00) begin errors++; $display("FAIL b2b_err%0d got %b%b exp 00", i, capPerr[base+i], capFerr[base+i]); end
      end
    end
  endtask

  task automatic test_reset_mid;
    int base;
    logic [7:0] d;
    d = 8'h55;
    base = capDout.size();
    sendBit(1'b0);
    for (int i = 7; i >= 4; i--) sendBit(d[i]);
    bus.RxIn = d[3];
    waitTicks(4);
    checks++; if (bus.Busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_pre got %b exp 1", bus.Busy); end
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    checks++; if (bus.Dout !== 8'h00) begin errors++; $display("FAIL rmid_dout got %h exp 00", bus.Dout); end
    checks++; if ({bus.DataValid, bus.ParityErr, bus.FrameErr, bus.Busy} !== 4'b0000) begin errors++; $display("FAIL rmid_flags got %b exp 0000", {bus.DataValid, bus.ParityErr, bus.FrameErr, bus.Busy}); end
    Reset = 1'b0;
    bus.RxIn = 1'b1;
    sendBit(1'b1);
    sendBit(1'b1);
    checks++; if (capDout.size() - base != 0) begin errors++; $display("FAIL rmid_nodv got %0d exp 0", capDout.size() - base); end
    sendFrame(8'h55, 1'b0, 1'b1);
    sendBit(1'b1);
    checks++; if (capDout.size() - base != 1) begin errors++; $display("FAIL rmid_count got %0d exp 1", capDout.size() - base); end
    if (capDout.size() - base >= 1) begin
      checks++; if (capDout[base] !== 8'h55) begin errors++; $display("FAIL rmid_dout2 got %h exp 55", capDout[base]); end
      checks++; if ({capPerr[base], capFerr[base]} !== 2'b00) begin errors++; $display("FAIL rmid_err got %b%b exp 00", capPerr[base], capFerr[base]); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset = 1'b1;
    bus.RxIn = 1'b1;
    test_reset;
    test_nominal;
    test_parity;
    test_break;
    test_glitch;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
